usbuart_rx_fifo: RTL
====================

Name: usbuart_rx_fifo

Overview:
- Receive-side byte FIFO directly downstream of the USB-UART interface on the 48 MHz domain.
- Accepts bytes and error strobes from the interface, returns full/depth status to it, and presents a first-word-fall-through valid/ready read port to the register/UART core side.
- Also provides a depth watermark, a sticky overflow flag and a saturating receive-error counter.

Parameters:
- Depth, 32, number of entries; must be a power of two, minimum 2.
- Width, 8, data bits per entry.
- DepthW, 6, count/watermark width; fixed equal to log2(Depth)+1, not overridden independently.

Ports:
- clk_48mhz_i  input  1  clock; all logic on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- clr_i  input  1  synchronous flush.
- wvalid_i  input  1  write strobe, one byte per asserted cycle (driven by interface rx_write).
- wdata_i  input  Width  write data (interface rx_fifo_wdata).
- werr_i  input  1  receive-error strobe (interface rx_err).
- full_o  output  1  FIFO full (to interface rx_full).
- wdepth_o  output  DepthW  current occupancy, 0..Depth (to interface rx_fifo_wdepth).
- rvalid_o  output  1  head entry valid.
- rready_i  input  1  consumer pops the head entry.
- rdata_o  output  Width  head entry data.
- rdata_err_o  output  1  error tag of head entry (see Optional Feature).
- watermark_i  input  DepthW  threshold level.
- watermark_o  output  1  occupancy at or above threshold.
- overflow_o  output  1  sticky overflow flag.
- overflow_clr_i  input  1  clears overflow_o.
- err_cnt_o  output  8  saturating count of werr_i strobes.

Behaviour:
- Reset: pointers and count 0; full_o 0; wdepth_o 0; rvalid_o 0; rdata_o and rdata_err_o don't-care while rvalid_o=0; overflow_o 0; err_cnt_o 0. watermark_o follows its rule, so it is 1 only if watermark_i==0. Storage is not reset.
- Storage: register array of Depth entries. Pointers are log2(Depth) bits and wrap naturally. Occupancy count is a separate DepthW register.
- Write accept: wvalid_i && !full_o && !clr_i. The entry is written at wptr and wptr increments.
- Write while full: data dropped, pointers and count unchanged, overflow_o set next cycle. A pop in the same cycle does not make room; full is judged on the registered count.
- Read: FWFT. rvalid_o = (count != 0). rdata_o is the entry at rptr. Pop when rvalid_o && rready_i && !clr_i; rptr then increments. rready_i while empty has no effect.
- Latency: a byte written into an empty FIFO sets rvalid_o on the next cycle. A pop advances rdata_o to the next entry on the next cycle.
- Count update:
  - +1 on write only.
  - -1 on pop only.
  - Unchanged on simultaneous write and pop. This is legal whenever 0 < count < Depth.
  - Never underflows or exceeds Depth.
- full_o = (count == Depth). wdepth_o = count. Both are registered-count derived, with no combinational path from wvalid_i or rready_i.
- watermark_o = (count >= watermark_i), unsigned compare. watermark_i > Depth gives a constant 0.
- clr_i has highest priority. Pointers and count go to 0 and err_cnt_o goes to 0 next cycle. Concurrent write, pop and werr_i are ignored. overflow_o is not affected by clr_i.
- overflow_o:
  - Set by a dropped write.
  - Cleared by overflow_clr_i.
  - A set event and a clear in the same cycle leave it set.
- err_cnt_o increments on each werr_i cycle, independent of wvalid_i and full_o, and saturates at 255.
- Reset mid-operation: immediate asynchronous return to the reset values above. Partially read data is lost.

Optional Feature:
- Macro: USBUART_RX_FIFO_ERR_TAG_EN.
- Defined: each entry stores Width+1 bits. werr_i sampled with an accepted write is stored as the tag. rdata_err_o presents the head entry's tag, so the consumer can discard or flag corrupted bytes in order.
- Not defined: entries are Width bits, rdata_err_o is tied to 0, and werr_i only feeds err_cnt_o.

Test Plan:
- Write 0x41, 0x42, 0x43 on consecutive cycles with rready_i=0 -> wdepth_o steps 1,2,3; rvalid_o rises the cycle after the first write; rdata_o=0x41. Pop three times -> rdata_o 0x42, 0x43, then rvalid_o=0, wdepth_o=0.
- Fill with 32 writes of 0x00..0x1F -> full_o=1, wdepth_o=32. 33rd write of 0xAA -> dropped, overflow_o=1. Drain -> data 0x00..0x1F in order with no 0xAA. Pulse overflow_clr_i -> overflow_o=0.
- Hold count at 10; assert write (0x55) and pop together for 20 cycles -> wdepth_o stays 10 and order is preserved across pointer wrap.
- watermark_i=4; write 4 bytes -> watermark_o=1 after the 4th write. Pop one -> watermark_o=0.
- With 5 entries and err_cnt_o=3, assert clr_i together with wvalid_i and werr_i -> next cycle wdepth_o=0, rvalid_o=0, err_cnt_o=0, overflow_o unchanged. 300 werr_i pulses afterwards -> err_cnt_o=255.
- With USBUART_RX_FIFO_ERR_TAG_EN: write 0x10 (werr_i=0), 0x11 (werr_i=1), 0x12 (werr_i=0) -> rdata_err_o reads 0,1,0 alongside the data. Without the macro -> rdata_err_o=0 throughout and err_cnt_o=1.

Source files
------------

// File: rtl/usbuart_rx_fifo.sv
// Receive byte FIFO (FWFT) between the USB-UART interface and the core side.
// Optional per-entry error tag: define USBUART_RX_FIFO_ERR_TAG_EN.
module usbuart_rx_fifo #(
    parameter int unsigned Depth = 32,
    parameter int unsigned Width = 8,
    localparam int unsigned DepthW = $clog2(Depth) + 1
) (
    input  logic              clk_48mhz_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wvalid_i,
    input  logic [Width-1:0]  wdata_i,
    input  logic              werr_i,
    output logic              full_o,
    output logic [DepthW-1:0] wdepth_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    output logic              rdata_err_o,
    input  logic [DepthW-1:0] watermark_i,
    output logic              watermark_o,
    output logic              overflow_o,
    input  logic              overflow_clr_i,
    output logic [7:0]        err_cnt_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [DepthW-1:0] DepthCnt = DepthW'(Depth);
`ifdef USBUART_RX_FIFO_ERR_TAG_EN
    localparam int unsigned EntW = Width + 1;
`else
    localparam int unsigned EntW = Width;
`endif

    logic [EntW-1:0]   mem_q [Depth];
    logic [EntW-1:0]   wentry;
    logic [EntW-1:0]   head;
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [DepthW-1:0] count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              wr_en, rd_en, ovf_set;

    assign full_o      = (count_q == DepthCnt);
    assign rvalid_o    = (count_q != '0);
    assign wdepth_o    = count_q;
    assign watermark_o = (count_q >= watermark_i);
    assign overflow_o  = ovf_q;
    assign err_cnt_o   = err_cnt_q;

    assign wr_en   = wvalid_i && !full_o && !clr_i;
    assign rd_en   = rvalid_o && rready_i && !clr_i;
    assign ovf_set = wvalid_i && full_o && !clr_i;

    assign head    = mem_q[rptr_q];
    assign rdata_o = head[Width-1:0];

`ifdef USBUART_RX_FIFO_ERR_TAG_EN
    assign wentry      = {werr_i, wdata_i};
    assign rdata_err_o = head[Width];
`else
    assign wentry      = wdata_i;
    assign rdata_err_o = 1'b0;
`endif

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        ovf_d     = ovf_q;
        if (clr_i) begin
            wptr_d    = '0;
            rptr_d    = '0;
            count_d   = '0;
            err_cnt_d = '0;
        end else begin
            if (wr_en) wptr_d = wptr_q + PtrW'(1);
            if (rd_en) rptr_d = rptr_q + PtrW'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + DepthW'(1);
                2'b01:   count_d = count_q - DepthW'(1);
                default: count_d = count_q;
            endcase
            if (werr_i && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
        // a drop and a clear in the same cycle keep the flag set
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (overflow_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // storage is intentionally left unreset
    always_ff @(posedge clk_48mhz_i) begin
        if (wr_en) mem_q[wptr_q] <= wentry;
    end

endmodule
